// File: rtl/sync_link_tx.sv
// sync_link_tx
//   Clocked valid/ready source to dual-rail asynchronous link transmitter.
//   Each accepted word becomes one dual-rail token: for bit i, rail 2i is the
//   "false" rail and rail 2i+1 the "true" rail. ENC selects two-phase
//   transition signalling ("TP") or four-phase return-to-zero ("FP").
//   Only one token is ever outstanding; the rail register is the only storage.
//
// Parameters
//   ENC          "TP" or "FP"; anything else stops elaboration.
//   WIDTH        data word width.
//   SYNC_STAGES  flops in the link_ack synchronizer (>= 2).
//
// Ports
//   clk        clock
//   rst        asynchronous active-low reset
//   in_data    word to send (sampled only on the accept edge)
//   in_valid   in_data valid
//   in_ready   registered: block accepts a word on the next edge
//   link_data  registered dual-rail rails, 2*WIDTH bits
//   link_ack   asynchronous acknowledge from the receiver
//   busy       token in flight
//   tok_cnt    completed-token count, wraps silently
//   err        sticky: acknowledge activity seen while idle
module sync_link_tx #(
  parameter              ENC         = "TP",
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] link_data,
  input  logic               link_ack,
  output logic               busy,
  output logic [15:0]        tok_cnt,
  output logic               err
);

  if (!((ENC == "TP") || (ENC == "FP"))) begin : g_bad_enc
    $error("sync_link_tx: ENC must be \"TP\" or \"FP\"");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sync_link_tx: SYNC_STAGES must be at least 2");
  end

  localparam bit IS_FP = (ENC == "FP");

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_HI,
    RTZ_WAIT_LO
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic                   ph, ph_d;
  logic [2*WIDTH-1:0]     sel;
  logic [2*WIDTH-1:0]     rails_d;
  logic                   done;
  logic                   err_d;
  logic                   accept;

  // Acknowledge synchronizer; nothing downstream looks at link_ack directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], link_ack};
  end

  assign ack_s  = sync_q[SYNC_STAGES-1];
  assign accept = in_valid & in_ready;

  // One-hot-per-bit rail selection: rail 2i+in_data[i].
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sel[2*i]   = ~in_data[i];
      sel[2*i+1] =  in_data[i];
    end
  end

  always_comb begin
    state_d = state;
    rails_d = link_data;
    ph_d    = ph;
    done    = 1'b0;
    err_d   = err;
    case (state)
      IDLE: begin
        // An idle link must not see acknowledge activity; flag it, but let
        // it disturb neither state, phase nor rails.
        if (IS_FP) begin
          if (ack_s) err_d = 1'b1;
        end else if (ack_s != ph) begin
          err_d = 1'b1;
        end
        if (accept) begin
          if (IS_FP) begin
            rails_d = sel;
            state_d = WAIT_HI;
          end else begin
            rails_d = link_data ^ sel;
            ph_d    = ~ph;
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        // ph already holds the new phase, so a matching ack closes the token.
        if (ack_s == ph) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      WAIT_HI: begin
        if (ack_s) begin
          rails_d = '0;
          state_d = RTZ_WAIT_LO;
        end
      end
      RTZ_WAIT_LO: begin
        if (!ack_s) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      link_data <= '0;
      ph        <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      tok_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      link_data <= rails_d;
      ph        <= ph_d;
      in_ready  <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      tok_cnt   <= tok_cnt + {15'd0, done};
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_sync_link_tx.sv
// Directed bench for sync_link_tx: one two-phase and one four-phase instance,
// both WIDTH=8, SYNC_STAGES=2. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_sync_link_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        tp_rst, tp_valid, tp_ready, tp_ack, tp_busy, tp_err;
  logic [7:0]  tp_data;
  logic [15:0] tp_link, tp_cnt;

  logic        fp_rst, fp_valid, fp_ready, fp_ack, fp_busy, fp_err;
  logic [7:0]  fp_data;
  logic [15:0] fp_link, fp_cnt;

  sync_link_tx #(.ENC("TP"), .WIDTH(8), .SYNC_STAGES(2)) u_tp (
    .clk       (clk),
    .rst       (tp_rst),
    .in_data   (tp_data),
    .in_valid  (tp_valid),
    .in_ready  (tp_ready),
    .link_data (tp_link),
    .link_ack  (tp_ack),
    .busy      (tp_busy),
    .tok_cnt   (tp_cnt),
    .err       (tp_err)
  );

  sync_link_tx #(.ENC("FP"), .WIDTH(8), .SYNC_STAGES(2)) u_fp (
    .clk       (clk),
    .rst       (fp_rst),
    .in_data   (fp_data),
    .in_valid  (fp_valid),
    .in_ready  (fp_ready),
    .link_data (fp_link),
    .link_ack  (fp_ack),
    .busy      (fp_busy),
    .tok_cnt   (fp_cnt),
    .err       (fp_err)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tp_reset();
    tp_rst   = 1'b0;
    tp_valid = 1'b0;
    tp_ack   = 1'b0;
    tick(2);
    tp_rst = 1'b1;
    tick(1);
  endtask

  // Presents a word for exactly one edge; caller has ready high.
  task automatic tp_send(input logic [7:0] d);
    tp_data  = d;
    tp_valid = 1'b1;
    tick(1);
    tp_valid = 1'b0;
  endtask

  task automatic fp_send(input logic [7:0] d);
    fp_data  = d;
    fp_valid = 1'b1;
    tick(1);
    fp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int unsigned bad_rdy, bad_rail, bad_busy;

  initial begin
    tp_rst = 1'b0; tp_valid = 1'b0; tp_data = '0; tp_ack = 1'b0;
    fp_rst = 1'b0; fp_valid = 1'b0; fp_data = '0; fp_ack = 1'b0;
    tick(2);

    // Reset state
    chk("tp_rst_link",  tp_link,  16'h0000);
    chk("tp_rst_ready", tp_ready, 1'b0);
    chk("tp_rst_busy",  tp_busy,  1'b0);
    chk("tp_rst_cnt",   tp_cnt,   16'h0000);
    chk("tp_rst_err",   tp_err,   1'b0);
    chk("fp_rst_link",  fp_link,  16'h0000);
    chk("fp_rst_ready", fp_ready, 1'b0);
    tp_rst = 1'b1;
    fp_rst = 1'b1;
    tick(1);
    chk("tp_first_ready", tp_ready, 1'b1);
    chk("fp_first_ready", fp_ready, 1'b1);

    // TP single token A5
    tp_send(8'hA5);
    chk("tp_a5_rails", tp_link,  16'h9966);
    chk("tp_a5_busy",  tp_busy,  1'b1);
    chk("tp_a5_ready", tp_ready, 1'b0);
    tp_data = 8'h00;
    tp_ack  = 1'b1;
    tick(2);
    chk("tp_a5_ready_2edges", tp_ready, 1'b0);
    tick(1);
    chk("tp_a5_ready_3edges", tp_ready, 1'b1);
    chk("tp_a5_cnt",   tp_cnt,  16'd1);
    chk("tp_a5_idle",  tp_busy, 1'b0);
    chk("tp_a5_rails_hold", tp_link, 16'h9966);

    // TP back-to-back FF then 00
    tp_reset();
    tp_send(8'hFF);
    chk("tp_ff_rails", tp_link, 16'hAAAA);
    tp_ack = 1'b1;
    tick(3);
    chk("tp_ff_ready", tp_ready, 1'b1);
    tp_send(8'h00);
    chk("tp_00_rails", tp_link, 16'hFFFF);
    tp_ack = 1'b0;
    tick(3);
    chk("tp_00_ready", tp_ready, 1'b1);
    tick(4);
    chk("tp_b2b_cnt", tp_cnt, 16'd2);
    chk("tp_b2b_err", tp_err, 1'b0);

    // Backpressure: valid held, ack frozen, data wandering
    tp_reset();
    tp_data  = 8'h5A;
    tp_valid = 1'b1;
    tick(1);
    chk("tp_bp_rails", tp_link, 16'h6699);
    bad_rdy = 0; bad_rail = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      tp_data = 8'(i * 37 + 1);
      tick(1);
      if (tp_ready !== 1'b0)      bad_rdy++;
      if (tp_link  !== 16'h6699)  bad_rail++;
      if (tp_busy  !== 1'b1)      bad_busy++;
    end
    chk("tp_bp_ready_cycles", bad_rdy,  0);
    chk("tp_bp_rail_cycles",  bad_rail, 0);
    chk("tp_bp_busy_cycles",  bad_busy, 0);
    tp_valid = 1'b0;
    tp_ack   = 1'b1;
    tick(3);
    chk("tp_bp_release_ready", tp_ready, 1'b1);
    chk("tp_bp_cnt",           tp_cnt,   16'd1);

    // Spurious ack while idle
    tp_reset();
    tp_ack = 1'b1;
    tick(2);
    chk("tp_spur_err_2edges", tp_err, 1'b0);
    tick(1);
    chk("tp_spur_err",   tp_err,   1'b1);
    chk("tp_spur_ready", tp_ready, 1'b1);
    chk("tp_spur_rails", tp_link,  16'h0000);
    tp_send(8'h3C);
    chk("tp_3c_rails", tp_link, 16'h5AA5);
    tick(2);
    chk("tp_3c_cnt",   tp_cnt, 16'd1);
    chk("tp_err_sticky", tp_err, 1'b1);

    // Reset mid-token
    tp_reset();
    chk("tp_rst_clears_err", tp_err, 1'b0);
    tp_send(8'hC3);
    chk("tp_c3_rails", tp_link, 16'hA55A);
    tick(1);
    #2 tp_rst = 1'b0;
    #1;
    chk("tp_midrst_rails", tp_link,  16'h0000);
    chk("tp_midrst_busy",  tp_busy,  1'b0);
    chk("tp_midrst_ready", tp_ready, 1'b0);
    tick(1);
    tp_rst = 1'b1;
    tick(1);
    chk("tp_midrst_first_ready", tp_ready, 1'b1);
    tp_send(8'hA5);
    chk("tp_after_rst_rails", tp_link, 16'h9966);
    tp_ack = 1'b1;
    tick(3);
    chk("tp_after_rst_ready", tp_ready, 1'b1);
    chk("tp_after_rst_cnt",   tp_cnt,   16'd1);

    // Counter wrap: preload near the top instead of 65536 real tokens
    force u_tp.tok_cnt = 16'hFFFE;
    tick(1);
    release u_tp.tok_cnt;
    tp_send(8'h00);
    chk("tp_wrap_rails1", tp_link, 16'hCC33);
    tp_ack = 1'b0;
    tick(3);
    chk("tp_wrap_ffff", tp_cnt, 16'hFFFF);
    tp_send(8'hFF);
    chk("tp_wrap_rails2", tp_link, 16'h6699);
    tp_ack = 1'b1;
    tick(3);
    chk("tp_wrap_zero",  tp_cnt,   16'h0000);
    chk("tp_wrap_ready", tp_ready, 1'b1);
    chk("tp_wrap_err",   tp_err,   1'b0);

    // FP token 01
    fp_send(8'h01);
    chk("fp_01_rails", fp_link,  16'h5556);
    chk("fp_01_busy",  fp_busy,  1'b1);
    chk("fp_01_ready", fp_ready, 1'b0);
    fp_ack = 1'b1;
    tick(2);
    chk("fp_01_rails_2edges", fp_link, 16'h5556);
    tick(1);
    chk("fp_01_rtz",       fp_link,  16'h0000);
    chk("fp_01_rtz_ready", fp_ready, 1'b0);
    fp_ack = 1'b0;
    tick(2);
    chk("fp_01_ready_2edges", fp_ready, 1'b0);
    tick(1);
    chk("fp_01_ready_3edges", fp_ready, 1'b1);
    chk("fp_01_cnt",  fp_cnt,  16'd1);
    chk("fp_01_idle", fp_busy, 1'b0);
    chk("fp_01_err",  fp_err,  1'b0);

    // FP token 80
    fp_send(8'h80);
    chk("fp_80_rails", fp_link, 16'h9555);
    fp_ack = 1'b1;
    tick(3);
    chk("fp_80_rtz", fp_link, 16'h0000);
    fp_ack = 1'b0;
    tick(3);
    chk("fp_80_ready", fp_ready, 1'b1);
    chk("fp_80_cnt",   fp_cnt,   16'd2);

    // FP spurious ack while idle
    fp_ack = 1'b1;
    tick(2);
    chk("fp_spur_err_2edges", fp_err, 1'b0);
    tick(1);
    chk("fp_spur_err",   fp_err,   1'b1);
    chk("fp_spur_ready", fp_ready, 1'b1);
    chk("fp_spur_rails", fp_link,  16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
